hwpe_stream_source_scheduler: RTL
=================================

Name: hwpe_stream_source_scheduler

Overview:
- Job sequencer in front of one streamer source.
- Queues up to QUEUE_DEPTH transfer descriptors from the controller or register file.
- Drives the source's start/addressgen control one job at a time, holding each descriptor stable for the whole job.
- Waits for the source's done pulse before issuing the next job, and reports progress and completion events.

Parameters:
- QUEUE_DEPTH, 4, descriptor FIFO depth; power of 2, ≥2.
- TRANS_CNT, 16, width of trans_size fields; matches the source.
- CNT_WIDTH, 16, width of the completed-jobs counter.
- TIMEOUT_CYCLES, 4096, watchdog limit (optional feature only).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- clear_i  in  1  synchronous clear
- enable_i  in  1  allow new job issue; 0 = pause after current job
- job_valid_i  in  1  descriptor push valid
- job_ready_o  out  1  descriptor push ready
- job_base_addr_i  in  32  job base address
- job_trans_size_i  in  TRANS_CNT  words in job; must be ≥1
- job_line_stride_i  in  16  line stride, bytes
- job_line_length_i  in  16  words per line
- src_req_start_o  out  1  start request to source
- src_ready_start_i  in  1  source idle/ready flag
- src_done_i  in  1  source done pulse
- src_clear_o  out  1  one-cycle clear to source
- src_base_addr_o  out  32  current job base address
- src_trans_size_o  out  TRANS_CNT  current job trans_size
- src_line_stride_o  out  16  current job line stride
- src_line_length_o  out  16  current job line length
- busy_o  out  1  job in flight (ISSUE or RUN)
- pending_o  out  $clog2(QUEUE_DEPTH)+1  queued jobs, not counting the in-flight job
- jobs_done_o  out  CNT_WIDTH  completed jobs since clear; wraps
- evt_all_done_o  out  1  one-cycle pulse: job completed and queue empty

Behaviour:
- Reset and clear_i: FIFO empty; FSM IDLE; all src_* descriptor outputs 0; src_req_start_o=0; busy_o=0; counters 0; evt_all_done_o=0. src_clear_o=0 at reset.
- clear_i in ISSUE or RUN: src_clear_o=1 in the following cycle, for one cycle only. clear_i in IDLE: src_clear_o stays 0. clear_i has priority over every other event.
- Push handshake:
  - job_ready_o = !full; independent of pops.
  - Push accepted when valid&ready at the clock edge.
  - valid&!ready: no write; the source must hold its data.
  - Full with a simultaneous pop: push still refused that cycle.
- FIFO: circular, read/write pointers wrap modulo QUEUE_DEPTH. pending_o counts entries; push+pop in the same cycle leaves it unchanged.
- FSM states:
  - IDLE: if !empty & enable_i, latch head into the current-descriptor register, pop the FIFO, go to ISSUE.
  - ISSUE: src_req_start_o=1. If src_ready_start_i=1 this cycle, go to RUN; otherwise stay. src_done_i is ignored.
  - RUN: src_req_start_o=0. On src_done_i:
    - jobs_done_o+1;
    - evt_all_done_o=1 if FIFO empty;
    - if !empty & enable_i, latch the next head, pop, go to ISSUE (back-to-back, no IDLE cycle);
    - else go to IDLE.
- Latency: push accepted at edge N into an empty queue while IDLE and enabled → ISSUE and descriptor valid after edge N+1. src_req_start_o is high from edge N+1 until the edge where src_ready_start_i is sampled 1.
- Descriptor outputs change only on the latch event; they hold their value through IDLE after completion.
- busy_o = (state≠IDLE).
- Dropping enable_i never aborts an in-flight job.

Optional Feature:
- Macro: HWPE_SOURCE_SCHEDULER_TIMEOUT_EN.
- Defined:
  - Watchdog counter resets on entering RUN and increments each RUN cycle.
  - On reaching TIMEOUT_CYCLES without src_done_i: src_clear_o pulses 1 cycle; the job is dropped (jobs_done_o unchanged); sticky err_timeout_o output=1 (cleared only by reset/clear_i); FSM to IDLE.
  - The queue is preserved.
- Undefined: no counter, no err_timeout_o port; RUN waits indefinitely.

Test Plan:
- Single job: push base 0x1000, trans_size 8 into idle scheduler, src_ready_start_i=1 → src_req_start_o high exactly 1 cycle starting 1 cycle after push; src_base_addr_o=0x1000; done pulse → jobs_done_o=1, evt_all_done_o pulse, busy_o=0.
- Fill: push 5 jobs with QUEUE_DEPTH=4 while source stalled in RUN → after the first job pops, 4 accepted, job_ready_o=0 on the 6th push, pending_o=4.
- Back-to-back: 3 queued jobs, done pulses → ISSUE follows RUN directly with no IDLE cycle; descriptors appear in push order; evt_all_done_o only after the 3rd; jobs_done_o=3.
- Pause: enable_i=0 during job 1 of 2 → job 1 completes, FSM IDLE, pending_o=1; enable_i=1 → job 2 issued next cycle.
- Clear mid-RUN: clear_i with 2 pending → src_clear_o 1-cycle pulse next cycle; pending_o=0, jobs_done_o=0, src_base_addr_o=0.
- Counter wrap (CNT_WIDTH=4): 17 jobs → jobs_done_o=1.

Source files
------------

// File: rtl/hwpe_stream_source_scheduler.sv
// hwpe_stream_source_scheduler
//
// Job sequencer placed in front of a single streamer source. Transfer
// descriptors are queued in a small circular FIFO and handed to the source
// one job at a time. Each descriptor is held stable for the whole job.
// The next job is issued only after the source reports done.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   clear_i                  synchronous clear (highest priority)
//   enable_i                 allow new jobs to be issued; 0 pauses after current job
//   job_valid_i/job_ready_o  descriptor push handshake
//   job_*_i                  descriptor fields pushed into the queue
//   src_req_start_o          start request to the source
//   src_ready_start_i        source idle/ready flag
//   src_done_i               source done pulse
//   src_clear_o              one-cycle clear to the source
//   src_*_o                  descriptor of the job in flight
//   busy_o                   job in flight (ISSUE or RUN)
//   pending_o                queued jobs, excluding the one in flight
//   jobs_done_o              completed jobs since clear, wrapping
//   evt_all_done_o           pulse: job completed with the queue empty
//   err_timeout_o            sticky watchdog error (watchdog build only)
//
// Optional feature: define HWPE_SOURCE_SCHEDULER_TIMEOUT_EN to add a RUN-state
// watchdog. When it expires, the job is dropped, the source is cleared, and
// err_timeout_o is set.

module hwpe_stream_source_scheduler #(
  parameter int unsigned QUEUE_DEPTH    = 4,
  parameter int unsigned TRANS_CNT      = 16,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           clear_i,
  input  logic                           enable_i,
  input  logic                           job_valid_i,
  output logic                           job_ready_o,
  input  logic [31:0]                    job_base_addr_i,
  input  logic [TRANS_CNT-1:0]           job_trans_size_i,
  input  logic [15:0]                    job_line_stride_i,
  input  logic [15:0]                    job_line_length_i,
  output logic                           src_req_start_o,
  input  logic                           src_ready_start_i,
  input  logic                           src_done_i,
  output logic                           src_clear_o,
  output logic [31:0]                    src_base_addr_o,
  output logic [TRANS_CNT-1:0]           src_trans_size_o,
  output logic [15:0]                    src_line_stride_o,
  output logic [15:0]                    src_line_length_o,
  output logic                           busy_o,
  output logic [$clog2(QUEUE_DEPTH):0]   pending_o,
  output logic [CNT_WIDTH-1:0]           jobs_done_o,
`ifdef HWPE_SOURCE_SCHEDULER_TIMEOUT_EN
  output logic                           err_timeout_o,
`endif
  output logic                           evt_all_done_o
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam logic [PTR_W:0] DEPTH_VAL = (PTR_W+1)'(QUEUE_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, RUN} state_e;

  state_e state_q, state_d;

  logic [31:0]          fifo_base   [QUEUE_DEPTH];
  logic [TRANS_CNT-1:0] fifo_trans  [QUEUE_DEPTH];
  logic [15:0]          fifo_stride [QUEUE_DEPTH];
  logic [15:0]          fifo_length [QUEUE_DEPTH];

  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]       count_q;
  logic                 full, empty, push, pop, job_done, timeout_hit;

  logic [31:0]          cur_base_q;
  logic [TRANS_CNT-1:0] cur_trans_q;
  logic [15:0]          cur_stride_q, cur_length_q;
  logic [CNT_WIDTH-1:0] jobs_done_q;
  logic                 evt_q, src_clear_q;

  assign full  = (count_q == DEPTH_VAL);
  assign empty = (count_q == '0);
  assign push  = job_valid_i && !full;

  // Descriptor storage. Pointers are reset by clear, so stale entries are
  // never read and the array itself needs no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_base[wr_ptr_q]   <= job_base_addr_i;
      fifo_trans[wr_ptr_q]  <= job_trans_size_i;
      fifo_stride[wr_ptr_q] <= job_line_stride_i;
      fifo_length[wr_ptr_q] <= job_line_length_i;
    end
  end

`ifdef HWPE_SOURCE_SCHEDULER_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt_q;
  logic            wd_expired, err_q;

  assign wd_expired    = (state_q == RUN) && (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign err_timeout_o = err_q;

  // The watchdog restarts from zero on every entry into RUN. The error flag
  // is sticky until reset or clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else if (clear_i) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wd_cnt_q <= (state_q == RUN) ? wd_cnt_q + 1'b1 : '0;
      err_q    <= err_q | timeout_hit;
    end
  end
`endif

  // Next-state logic. A pop always coincides with latching the head into
  // the current-descriptor register. This happens either from IDLE or
  // directly out of RUN, so back-to-back jobs skip the IDLE cycle.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    job_done    = 1'b0;
    timeout_hit = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty && enable_i) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (src_ready_start_i) state_d = RUN;
      end
      RUN: begin
        if (src_done_i) begin
          job_done = 1'b1;
          if (!empty && enable_i) begin
            pop     = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
`ifdef HWPE_SOURCE_SCHEDULER_TIMEOUT_EN
        else if (wd_expired) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; clear forces IDLE ahead of any transition.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      state_q <= IDLE;
    else if (clear_i) state_q <= IDLE;
    else              state_q <= state_d;
  end

  // Queue bookkeeping, current descriptor, completion counter and events.
  // The source is cleared only if clear arrives while a job is in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      cur_base_q   <= '0;
      cur_trans_q  <= '0;
      cur_stride_q <= '0;
      cur_length_q <= '0;
      jobs_done_q  <= '0;
      evt_q        <= 1'b0;
      src_clear_q  <= 1'b0;
    end else if (clear_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      cur_base_q   <= '0;
      cur_trans_q  <= '0;
      cur_stride_q <= '0;
      cur_length_q <= '0;
      jobs_done_q  <= '0;
      evt_q        <= 1'b0;
      src_clear_q  <= (state_q != IDLE);
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q     <= rd_ptr_q + 1'b1;
        cur_base_q   <= fifo_base[rd_ptr_q];
        cur_trans_q  <= fifo_trans[rd_ptr_q];
        cur_stride_q <= fifo_stride[rd_ptr_q];
        cur_length_q <= fifo_length[rd_ptr_q];
      end
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
      if (job_done) jobs_done_q <= jobs_done_q + 1'b1;
      evt_q       <= job_done && empty;
      src_clear_q <= timeout_hit;
    end
  end

  assign job_ready_o       = !full;
  assign src_req_start_o   = (state_q == ISSUE);
  assign src_clear_o       = src_clear_q;
  assign src_base_addr_o   = cur_base_q;
  assign src_trans_size_o  = cur_trans_q;
  assign src_line_stride_o = cur_stride_q;
  assign src_line_length_o = cur_length_q;
  assign busy_o            = (state_q != IDLE);
  assign pending_o         = count_q;
  assign jobs_done_o       = jobs_done_q;
  assign evt_all_done_o    = evt_q;

endmodule
